// File: rtl/ctc_seq.sv
// ctc_seq: control-and-timing sequencer. Runs the 56-bit-time word counter,
// fetches one 10-bit instruction per word over a valid/ready handshake,
// serialises it LSB-first on `is` under `sync`, owns the pointer register and
// derives the word-select `ws` for arithmetic instructions in the next word.
module ctc_seq #(
    parameter int         WORD_LEN = 56,
    parameter logic [3:0] P_RST    = 4'd0
) (
    input  logic       cph2,
    input  logic       rstb,
    input  logic [9:0] ins_data,
    input  logic       ins_valid,
    output logic       ins_ready,
    output logic       is,
    output logic       sync,
    output logic       ws,
    output logic [5:0] sys_cnt,
    output logic [3:0] p_out
);

    localparam logic [5:0] CNT_LAST  = 6'(WORD_LEN - 1);
    localparam logic [5:0] CNT_FETCH = 6'd44;
    localparam logic [5:0] CNT_SER0  = 6'd45;
    localparam logic [5:0] CNT_SERL  = 6'd54;
    localparam logic [3:0] P_MAX     = 4'd13;

    logic [5:0] cnt_q,     cnt_d;
    logic [9:0] shreg_q,   shreg_d;
    logic [9:0] ir_q,      ir_d;
    logic       ar_en_q,   ar_en_d;
    logic [2:0] ar_type_q, ar_type_d;
    logic [3:0] p_q,       p_d;
    logic [3:0] dig;

    // Pointer update for a pointer-op instruction held in `ir`.
    function automatic logic [3:0] ptr_next(input logic [3:0] p, input logic [9:0] ir);
        logic [3:0] r;
        r = p;
        case (ir[5:4])
            2'b00:   r = (ir[9:6] > P_MAX) ? P_MAX : ir[9:6];
            2'b01:   r = (p == P_MAX) ? 4'd0 : p + 4'd1;
            2'b10:   r = (p == 4'd0) ? P_MAX : p - 4'd1;
            default: r = p;
        endcase
        return r;
    endfunction

    // State registers; a reset mid-word drops any partially shifted instruction.
    always_ff @(posedge cph2 or negedge rstb) begin
        if (!rstb) begin
            cnt_q     <= 6'd0;
            shreg_q   <= 10'd0;
            ir_q      <= 10'd0;
            ar_en_q   <= 1'b0;
            ar_type_q <= 3'd0;
            p_q       <= P_RST;
        end else begin
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            ir_q      <= ir_d;
            ar_en_q   <= ar_en_d;
            ar_type_q <= ar_type_d;
            p_q       <= p_d;
        end
    end

    // Next state: counter wrap, fetch at 44, shift in 45..53, decode on the 55->0 edge.
    always_comb begin
        cnt_d     = (cnt_q == CNT_LAST) ? 6'd0 : cnt_q + 6'd1;
        shreg_d   = shreg_q;
        ir_d      = ir_q;
        ar_en_d   = ar_en_q;
        ar_type_d = ar_type_q;
        p_d       = p_q;

        if (cnt_q == CNT_FETCH) begin
            // A missing instruction becomes a NOP (all zeros).
            shreg_d = ins_valid ? ins_data : 10'd0;
            ir_d    = ins_valid ? ins_data : 10'd0;
        end else if (cnt_q >= CNT_SER0 && cnt_q < CNT_SERL) begin
            shreg_d = {1'b0, shreg_q[9:1]};
        end

        if (cnt_q == CNT_LAST) begin
            ar_en_d = (ir_q[1:0] == 2'b10);
            if (ir_q[1:0] == 2'b10) begin
                ar_type_d = ir_q[4:2];
            end
            if (ir_q[3:0] == 4'b1100) begin
                p_d = ptr_next(p_q, ir_q);
            end
        end
    end

    assign dig = cnt_q[5:2];

    // Outputs decoded purely from registered state.
    always_comb begin
        sync      = (cnt_q >= CNT_SER0) && (cnt_q <= CNT_SERL);
        ins_ready = (cnt_q == CNT_FETCH);
        is        = sync & shreg_q[0];
        sys_cnt   = cnt_q;
        p_out     = p_q;
        ws        = 1'b1;
        if (ar_en_q) begin
            case (ar_type_q)
                3'b000:  ws = (dig == p_q);
                3'b001:  ws = (dig >= 4'd3) && (dig <= 4'd12);
                3'b010:  ws = (dig <= 4'd2);
                3'b011:  ws = 1'b1;
                3'b100:  ws = (dig <= p_q);
                3'b101:  ws = (dig >= 4'd3);
                3'b110:  ws = (dig == 4'd2);
                default: ws = (dig == 4'd13);
            endcase
        end
    end

endmodule

// File: doc/ctc_seq.md
# ctc_seq

Control-and-timing sequencer: the transmitting end of the instruction/timing bus consumed by the arithmetic register circuit. It runs the 56-bit-time word-cycle counter, accepts one 10-bit instruction per word from the ROM side through a valid/ready handshake, and serialises it LSB-first on `is` under `sync`. It also owns the pointer register, and derives `ws` for arithmetic instructions in the following word.

## Interface
Parameters:
- `WORD_LEN`, 56: bit times per word cycle; fixed, not tested at other values.
- `P_RST`, 0: pointer value after reset (0..13).

Ports:
- `cph2`  in  1  system clock (single clock; all state on posedge).
- `rstb`  in  1  reset, asynchronous, active-low.
- `ins_data`  in  10  instruction word from ROM side.
- `ins_valid`  in  1  `ins_data` is valid.
- `ins_ready`  out  1  high for exactly one cycle per word, at `sys_cnt==44`.
- `is`  out  1  serial instruction bit.
- `sync`  out  1  high while `sys_cnt` is in 45..54.
- `ws`  out  1  word select for the arithmetic circuit.
- `sys_cnt`  out  6  bit-time counter, 0..55.
- `p_out`  out  4  current pointer, 0..13.

## Operation
- Counter `sys_cnt` increments each cycle and wraps 55->0. Digit index `dig = sys_cnt[5:2]` (0..13).
- Fetch: on the edge with `sys_cnt==44`:
  - If `ins_valid` is high, load `ins_data` into the shift register and the hold register `ir`.
  - Otherwise load 0 (NOP).
  - `ins_valid` is ignored at every other count. The source holds data until it sees `ins_ready && ins_valid`.
- Serialise: `is = shreg[0]` while `sys_cnt` is in 45..54. `shreg` shifts right on each edge with `sys_cnt` in 45..53. `is=0` outside that window. Bit k of the instruction appears at `sys_cnt==45+k`.
- Decode: on the 55->0 edge, `ir` is decoded and takes effect for the whole next word.
  - Arithmetic (`ir[1:0]==2'b10`): set `ar_en=1`, `ar_type=ir[4:2]`.
  - All other instructions: `ar_en=0`.
  - Pointer op (`ir[3:0]==4'b1100`), selected by `ir[5:4]`:
    - 00: p = `ir[9:6]`; values 14/15 load 13.
    - 01: p = p+1; 13 wraps to 0.
    - 10: p = p-1; 0 wraps to 13.
    - 11: no change.
  - A pointer op is never an arithmetic op, so p and `ar_en` never change from the same instruction.
- `ws` when `ar_en=0`: `ws=1`.
- `ws` when `ar_en=1`, selected by `ar_type`:
  - 000 [p]: `dig==p`
  - 001 [m]: `dig` in 3..12
  - 010 [x]: `dig<=2`
  - 011 [w]: 1
  - 100 [wp]: `dig<=p`
  - 101 [ms]: `dig` in 3..13
  - 110 [xs]: `dig==2`
  - 111 [s]: `dig==13`
- `ws` uses the updated p, i.e. the value in effect for the current word.

## Timing
- Reset values: `sys_cnt=0`, `shreg=0`, `ir=0`, `ar_en=0`, `ar_type=0`, `p=P_RST`. Outputs: `is=0`, `sync=0`, `ins_ready=0`, `ws=1`, `p_out=P_RST`.
- `is`, `sync`, `ws`, `ins_ready` and `p_out` decode from registered state only. There is no combinational path from any input to any output.
- Latency:
  - Handshake at count 44 -> first bit on `is` 1 cycle later (count 45).
  - Last bit at count 54.
  - Decoded `ws`/p effect starts at count 0 of the next word, 2 cycles after the last bit.
- Back-to-back: one instruction per word. A word accepted in word N drives `ws` through word N+1 while word N+1's instruction is being serialised.
- Reset mid-word: everything returns to reset values immediately. A partially shifted instruction is discarded and is not re-requested. The source must treat it as lost.
- Reset release: the first `ins_ready` occurs 44 edges after `rstb` rises.

## Test plan
- Reset -> all outputs at reset values. After release, `sync` is high for counts 45..54 only, `ins_ready` pulses once at 44, and the period is 56 cycles.
- `ins_valid` low at count 44 -> `is=0` through the whole window, `ws=1` next word, p unchanged.
- Send `10'b11111_000_10` -> `is` at counts 45..54 reads 0,1,0,0,0,1,1,1,1,1. Next word `ws=1` only at `dig==P_RST` (counts 0..3 with P_RST=0).
- Set p=5 (`10'b0101_00_1100`), then `[wp]` (`10'b11111_100_10`) -> `p_out=5`, `ws` high for counts 0..23, low for 24..55.
- p=13 then p+1 (`10'b0000_01_1100`) -> `p_out=0`. Then p-1 -> 13. Set to 15 -> 13.
- `ins_valid` raised at count 20 and held -> consumed only at count 44 (single `ins_ready`). Reset asserted at count 50 -> `is`/`sync` drop immediately, `ws=1`.
